// File: rtl/vid_frame_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vid_frame_writer                                                         |
// | Crops a pixel stream to a window, packs PPW pixels per word and writes   |
// | each line over a pipelined Wishbone master at base + line*stride.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module vid_frame_writer #(
  parameter int DW     = 32,
  parameter int PW     = 32,
  parameter int AW     = 30,
  parameter int LGFIFO = 5,
  parameter int LGDIM  = 12
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic              i_continuous,
  input  logic [AW-1:0]     i_base,
  input  logic [AW-1:0]     i_stride,
  input  logic [LGDIM-1:0]  i_first_x,
  input  logic [LGDIM-1:0]  i_first_y,
  input  logic [LGDIM-1:0]  i_xcount,
  input  logic [LGDIM-1:0]  i_ycount,
  input  logic              i_pix_valid,
  input  logic [PW-1:0]     i_pix_data,
  input  logic              i_pix_eol,
  input  logic              i_pix_eof,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [AW-1:0]     o_wb_addr,
  output logic [DW-1:0]     o_wb_data,
  output logic [DW/8-1:0]   o_wb_sel,
  input  logic              i_wb_ack,
  input  logic              i_wb_stall,
  input  logic              i_wb_err,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_overflow,
  output logic              o_err
);

  localparam int c_PPW   = DW / PW;
  localparam int c_SW    = DW / 8;
  localparam int c_PB    = PW / 8;
  localparam int c_SLW   = (c_PPW > 1) ? $clog2(c_PPW) : 1;
  localparam int c_DEPTH = 1 << LGFIFO;
  localparam int c_FW    = AW + c_SW + DW;
  localparam logic [LGFIFO:0] c_FULL    = {1'b1, {LGFIFO{1'b0}}};
  localparam logic [LGFIFO:0] c_OUT_ONE = (LGFIFO+1)'(1);
  localparam logic [LGDIM:0]  c_X_ONE   = (LGDIM+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SYNC   = 2'd1,
    S_ACTIVE = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_en_d, r_frame_done, r_overflow, r_err;
  logic [LGDIM-1:0]  r_x, r_y;
  logic [LGDIM-1:0]  r_fx, r_fy, r_xc, r_yc;
  logic [AW-1:0]     r_stride, r_line_addr, r_widx;
  logic [c_SLW-1:0]  r_slot;
  logic [DW-1:0]     r_word;
  logic [c_SW-1:0]   r_sel;
  logic [LGFIFO:0]   r_wp, r_rp, r_outst;
  logic [c_FW-1:0]   r_mem [c_DEPTH];

  logic [DW-1:0]     w_word;
  logic [c_SW-1:0]   w_sel;
  logic [LGDIM:0]    w_x1, w_y1, w_xend, w_yend;
  logic              w_in_win, w_last, w_cap, w_push_req, w_push, w_pop, w_ack;
  logic              w_empty, w_full, w_stb, w_cyc, w_err, w_drained, w_latch;
  logic [AW-1:0]     w_push_addr;
  logic [c_FW-1:0]   w_head;

  // Window bounds are compared one bit wider so first+count never wraps.
  assign w_x1   = {1'b0, r_x};
  assign w_y1   = {1'b0, r_y};
  assign w_xend = {1'b0, r_fx} + {1'b0, r_xc};
  assign w_yend = {1'b0, r_fy} + {1'b0, r_yc};
  assign w_in_win = (w_x1 >= {1'b0, r_fx}) && ((r_xc == '0) || (w_x1 < w_xend)) &&
                    (w_y1 >= {1'b0, r_fy}) && ((r_yc == '0) || (w_y1 < w_yend));
  assign w_last = i_pix_eol || ((r_xc != '0) && ((w_x1 + c_X_ONE) == w_xend));

  assign w_empty   = (r_wp == r_rp);
  assign w_full    = ((r_wp - r_rp) == c_FULL);
  assign w_stb     = !w_empty && !i_reset;
  assign w_cyc     = (!w_empty || (r_outst != '0)) && !i_reset;
  assign w_err     = i_wb_err && w_cyc;
  assign w_pop     = w_stb && !i_wb_stall;
  assign w_ack     = i_wb_ack && (r_outst != '0);
  assign w_drained = w_empty && (r_outst == '0);

  assign w_cap       = (r_state == S_ACTIVE) && i_pix_valid && w_in_win && !w_err;
  assign w_push_req  = w_cap && ((r_slot == c_SLW'(c_PPW-1)) || w_last);
  assign w_push      = w_push_req && !w_full;
  assign w_push_addr = r_line_addr + r_widx;
  assign w_latch     = ((r_state == S_SYNC) && i_en && i_pix_valid && i_pix_eof) ||
                       ((r_state == S_DRAIN) && !w_err && w_drained && i_continuous && i_en);

  // First window pixel of a word lands in the most significant slot.
  always_comb begin
    w_word = r_word;
    w_sel  = r_sel;
    for (int k = 0; k < c_PPW; k++) begin
      if (r_slot == c_SLW'(k)) begin
        w_word[DW-1-k*PW -: PW]     = i_pix_data;
        w_sel[c_SW-1-k*c_PB -: c_PB] = '1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp[LGFIFO-1:0]] <= {w_push_addr, w_sel, w_word};
  end

  assign w_head    = r_mem[r_rp[LGFIFO-1:0]];
  assign o_wb_cyc  = w_cyc;
  assign o_wb_stb  = w_stb;
  assign o_wb_we   = 1'b1;
  assign o_wb_addr = w_stb ? w_head[c_FW-1 -: AW] : '0;
  assign o_wb_sel  = w_stb ? w_head[DW+c_SW-1 -: c_SW] : '0;
  assign o_wb_data = w_stb ? w_head[DW-1:0] : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_outst <= '0;
    end else if (w_err) begin
      r_rp    <= r_wp;
      r_outst <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + c_OUT_ONE;
      if (w_pop)  r_rp <= r_rp + c_OUT_ONE;
      case ({w_pop, w_ack})
        2'b10:   r_outst <= r_outst + c_OUT_ONE;
        2'b01:   r_outst <= r_outst - c_OUT_ONE;
        default: r_outst <= r_outst;
      endcase
    end
  end

  // Stream position runs continuously so capture can start at any frame boundary.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_pix_valid) begin
      if (i_pix_eol) begin
        r_x <= '0;
        r_y <= i_pix_eof ? '0 : r_y + LGDIM'(1);
      end else begin
        r_x <= r_x + LGDIM'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_en_d       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_err        <= 1'b0;
      r_fx         <= '0;
      r_fy         <= '0;
      r_xc         <= '0;
      r_yc         <= '0;
      r_stride     <= '0;
      r_line_addr  <= '0;
      r_widx       <= '0;
      r_slot       <= '0;
      r_word       <= '0;
      r_sel        <= '0;
    end else begin
      r_en_d       <= i_en;
      r_frame_done <= 1'b0;
      if (i_en && !r_en_d) begin
        r_overflow <= 1'b0;
        r_err      <= 1'b0;
      end
      if (w_push_req && w_full) r_overflow <= 1'b1;
      if (w_err)                r_err      <= 1'b1;

      if (w_latch) begin
        r_fx        <= i_first_x;
        r_fy        <= i_first_y;
        r_xc        <= i_xcount;
        r_yc        <= i_ycount;
        r_stride    <= i_stride;
        r_line_addr <= i_base;
        r_widx      <= '0;
        r_slot      <= '0;
        r_word      <= '0;
        r_sel       <= '0;
      end else if (w_cap) begin
        if (w_push_req) begin
          r_slot <= '0;
          r_word <= '0;
          r_sel  <= '0;
          if (w_last) begin
            r_widx      <= '0;
            r_line_addr <= r_line_addr + r_stride;
          end else begin
            r_widx <= r_widx + AW'(1);
          end
        end else begin
          r_slot <= r_slot + c_SLW'(1);
          r_word <= w_word;
          r_sel  <= w_sel;
        end
      end

      case (r_state)
        S_IDLE: if (i_en) r_state <= S_SYNC;
        S_SYNC: begin
          if (!i_en)        r_state <= S_IDLE;
          else if (w_latch) r_state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (w_err)                           r_state <= i_en ? S_SYNC : S_IDLE;
          else if (i_pix_valid && i_pix_eof)   r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_err) begin
            r_state <= i_en ? S_SYNC : S_IDLE;
          end else if (w_drained) begin
            r_frame_done <= 1'b1;
            r_state      <= w_latch ? S_ACTIVE : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy       = (r_state != S_IDLE);
  assign o_frame_done = r_frame_done;
  assign o_overflow   = r_overflow;
  assign o_err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vid_frame_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vid_frame_writer                                                      |
// | Scoreboarded bench: DW=64, PW=16 (4 pixels/word), 8-entry write FIFO.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_vid_frame_writer;

  localparam int DW = 64, PW = 16, AW = 16, LGFIFO = 3, LGDIM = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    sel;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst, en, cont, pv, peol, peof, ack, stall, err;
  logic [AW-1:0] base, stride;
  logic [LGDIM-1:0] fx, fy, xc, yc;
  logic [PW-1:0] pdata;
  logic cyc, stb, we, busy, done, ovf, oerr;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [7:0] sel;

  exp_t q[$];
  int checks = 0, errors = 0;
  int pending = 0, done_cnt = 0, ack_no = 0, err_at = 0;
  logic err_fired = 1'b0, chk_err_next = 1'b0;

  vid_frame_writer #(.DW(DW), .PW(PW), .AW(AW), .LGFIFO(LGFIFO), .LGDIM(LGDIM)) dut (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_continuous(cont),
    .i_base(base), .i_stride(stride), .i_first_x(fx), .i_first_y(fy),
    .i_xcount(xc), .i_ycount(yc), .i_pix_valid(pv), .i_pix_data(pdata),
    .i_pix_eol(peol), .i_pix_eof(peof), .o_wb_cyc(cyc), .o_wb_stb(stb),
    .o_wb_we(we), .o_wb_addr(addr), .o_wb_data(data), .o_wb_sel(sel),
    .i_wb_ack(ack), .i_wb_stall(stall), .i_wb_err(err), .o_busy(busy),
    .o_frame_done(done), .o_overflow(ovf), .o_err(oerr)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pix(input logic [31:0] tag, input logic [31:0] x, input logic [31:0] y);
    return {tag[3:0], y[3:0], x[7:0]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every accepted write against the scoreboard head.
  always @(negedge clk) begin
    if (cyc && stb && !stall) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%h sel=%h data=%h expected none", addr, sel, data);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("write", {40'h0, addr, sel, data}, {40'h0, e.addr, e.sel, e.data});
      end
      pending++;
    end
    if (ack) begin
      check("cyc_during_ack", {127'h0, cyc}, 128'h1);
      pending--;
    end
    if (!cyc) pending = 0;
    if (done) done_cnt++;
  end

  // Slave: one ack per accepted write, optionally an error in place of an ack.
  always @(posedge clk) begin
    #1;
    if (chk_err_next) begin
      check("err_cyc_low", {126'h0, cyc, stb}, 128'h0);
      check("err_sticky", {127'h0, oerr}, 128'h1);
      chk_err_next = 1'b0;
    end
    if (pending > 0 && cyc) begin
      if (err_at != 0 && !err_fired && ack_no + 1 == err_at) begin
        err = 1'b1;
        ack = 1'b0;
        err_fired = 1'b1;
        chk_err_next = 1'b1;
      end else begin
        ack = 1'b1;
        err = 1'b0;
        ack_no++;
      end
    end else begin
      ack = 1'b0;
      err = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [AW-1:0] b, s, input int x0, y0, xn, yn, input logic c);
    base = b; stride = s; cont = c;
    fx = LGDIM'(x0); fy = LGDIM'(y0); xc = LGDIM'(xn); yc = LGDIM'(yn);
  endtask

  task automatic enable();
    tick(1); en = 1'b0;
    tick(1); en = 1'b1;
    tick(2);
  endtask

  task automatic send_frame(input int w, h, tag, hook, input logic hen, input logic [AW-1:0] hbase);
    int idx = 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        @(posedge clk); #1;
        if (idx == hook) begin en = hen; base = hbase; end
        pv = 1'b1;
        pdata = pix(tag, x, y);
        peol = (x == w - 1);
        peof = (x == w - 1) && (y == h - 1);
        idx++;
      end
    end
    @(posedge clk); #1;
    pv = 1'b0; peol = 1'b0; peof = 1'b0;
  endtask

  task automatic push_model(input int w, h, x0, y0, xn, yn, input logic [AW-1:0] b, s, input int tag);
    logic [AW-1:0] la;
    la = b;
    for (int y = 0; y < h; y++) begin
      if (y >= y0 && (yn == 0 || y < y0 + yn)) begin
        exp_t e;
        int n = 0, widx = 0;
        logic any = 1'b0;
        e = '0;
        for (int x = 0; x < w; x++) begin
          if (x >= x0 && (xn == 0 || x < x0 + xn)) begin
            e.data[63-16*n -: 16] = pix(tag, x, y);
            e.sel[7-2*n -: 2] = 2'b11;
            n++;
            if (n == 4 || x == w - 1 || (xn != 0 && x == x0 + xn - 1)) begin
              e.addr = la + AW'(widx);
              q.push_back(e);
              e = '0; n = 0; widx++; any = 1'b1;
            end
          end
        end
        if (any) la = la + s;
      end
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((q.size() != 0 || cyc) && n < budget) begin
      tick(1);
      n++;
    end
    check(name, {95'h0, cyc, q.size()}, 128'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    exp_t e;
    rst = 1'b1; en = 1'b0; cont = 1'b0; pv = 1'b0; peol = 1'b0; peof = 1'b0;
    pdata = '0; stall = 1'b0; ack = 1'b0; err = 1'b0;
    setup(16'h0, 16'h0, 0, 0, 0, 0, 1'b0);
    tick(3);
    rst = 1'b0;
    tick(1);
    check("reset_outs", {106'h0, cyc, stb, busy, done, ovf, oerr, addr},  128'h0);
    check("reset_data", {56'h0, sel, data}, 128'h0);

    // Full frame, single shot: 8x4 frame -> two words per line.
    setup(16'h100, 16'h8, 0, 0, 0, 0, 1'b0);
    enable();
    check("sync_busy", {127'h0, busy}, 128'h1);
    send_frame(4, 1, 15, -1, 1'b1, 16'h100);
    push_model(8, 4, 0, 0, 0, 0, 16'h100, 16'h8, 1);
    d0 = done_cnt;
    send_frame(8, 4, 1, 10, 1'b0, 16'h100);
    wait_drain("full_drain", 200);
    tick(3);
    check("full_done", 128'(done_cnt - d0), 128'd1);
    check("full_idle", {127'h0, busy}, 128'h0);

    // Crop: x 2..4 of lines 1,2, one partial word per line.
    setup(16'h200, 16'h10, 2, 1, 3, 2, 1'b0);
    enable();
    send_frame(4, 1, 15, -1, 1'b1, 16'h200);
    for (int y = 1; y <= 2; y++) begin
      e.addr = 16'h200 + AW'(16 * (y - 1));
      e.sel  = 8'hFC;
      e.data = {pix(2, 2, y), pix(2, 3, y), pix(2, 4, y), 16'h0};
      q.push_back(e);
    end
    d0 = done_cnt;
    send_frame(8, 4, 2, 5, 1'b0, 16'h200);
    wait_drain("crop_drain", 200);
    tick(3);
    check("crop_done", 128'(done_cnt - d0), 128'd1);

    // Packing: 6-pixel lines -> full word then half word.
    setup(16'h300, 16'h4, 0, 0, 0, 0, 1'b0);
    enable();
    send_frame(4, 1, 15, -1, 1'b1, 16'h300);
    for (int y = 0; y < 2; y++) begin
      e.addr = 16'h300 + AW'(4 * y);
      e.sel  = 8'hFF;
      e.data = {pix(3, 0, y), pix(3, 1, y), pix(3, 2, y), pix(3, 3, y)};
      q.push_back(e);
      e.addr = 16'h301 + AW'(4 * y);
      e.sel  = 8'hF0;
      e.data = {pix(3, 4, y), pix(3, 5, y), 32'h0};
      q.push_back(e);
    end
    send_frame(6, 2, 3, 2, 1'b0, 16'h300);
    wait_drain("pack_drain", 200);

    // Backpressure: 16-word line into an 8-deep FIFO held stalled.
    setup(16'h400, 16'h20, 0, 0, 0, 1, 1'b0);
    enable();
    send_frame(4, 1, 15, -1, 1'b1, 16'h400);
    stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e.addr = 16'h400 + AW'(i);
      e.sel  = 8'hFF;
      e.data = {pix(4, 4*i, 0), pix(4, 4*i+1, 0), pix(4, 4*i+2, 0), pix(4, 4*i+3, 0)};
      q.push_back(e);
    end
    d0 = done_cnt;
    send_frame(64, 2, 4, 3, 1'b0, 16'h400);
    tick(10);
    check("stall_ovf", {127'h0, ovf}, 128'h1);
    check("stall_head", {111'h0, cyc, addr}, {111'h1, 16'h400});
    check("stall_no_done", 128'(done_cnt - d0), 128'd0);
    stall = 1'b0;
    wait_drain("stall_drain", 200);
    tick(3);
    check("stall_done", 128'(done_cnt - d0), 128'd1);

    // Bus error on the third ack, continuous capture resumes next frame.
    setup(16'h500, 16'h8, 0, 0, 0, 0, 1'b1);
    enable();
    check("ovf_cleared", {127'h0, ovf}, 128'h0);
    send_frame(4, 1, 15, -1, 1'b1, 16'h500);
    err_at = ack_no + 3;
    push_model(8, 4, 0, 0, 0, 0, 16'h500, 16'h8, 5);
    d0 = done_cnt;
    send_frame(8, 4, 5, -1, 1'b1, 16'h500);
    tick(5);
    check("err_fired", {127'h0, err_fired}, 128'h1);
    check("err_no_done", 128'(done_cnt - d0), 128'd0);
    check("err_bus_idle", {127'h0, cyc}, 128'h0);
    q.delete();
    push_model(8, 4, 0, 0, 0, 0, 16'h500, 16'h8, 6);
    send_frame(8, 4, 6, 20, 1'b0, 16'h500);
    wait_drain("resume_drain", 200);
    tick(3);
    check("resume_done", 128'(done_cnt - d0), 128'd1);

    // Base changed mid-frame applies from the next frame.
    setup(16'h600, 16'h8, 0, 0, 0, 0, 1'b1);
    enable();
    check("err_cleared", {127'h0, oerr}, 128'h0);
    send_frame(4, 1, 15, -1, 1'b1, 16'h600);
    push_model(8, 4, 0, 0, 0, 0, 16'h600, 16'h8, 7);
    d0 = done_cnt;
    send_frame(8, 4, 7, 12, 1'b1, 16'h700);
    wait_drain("cfgA_drain", 200);
    tick(3);
    push_model(8, 4, 0, 0, 0, 0, 16'h700, 16'h8, 8);
    send_frame(8, 4, 8, 5, 1'b0, 16'h700);
    wait_drain("cfgB_drain", 200);
    tick(3);
    check("cfg_done", 128'(done_cnt - d0), 128'd2);
    check("cfg_idle", {127'h0, busy}, 128'h0);

    check("final_queue", 128'(q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
